// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake, RAM port and debug counters of mem_access_ctrl.
// The master modport is the requester/RAM side; the slave modport is the controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  wr_done;

  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  logic [CNT_WIDTH-1:0]  wr_count;
  logic [CNT_WIDTH-1:0]  rd_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, wr_done,
    input  mem_en, mem_addr, mem_wdata, wr_count, rd_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, wr_done,
    output mem_en, mem_addr, mem_wdata, wr_count, rd_count
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request controller in front of a single-port RAM with registered read data.
// Sequences one write (2 cycles) or one read (3 cycles plus backpressure) at a time.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic                  accept, commit, capture, consume;

  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic                  rsp_err_reg;
  logic                  rsp_valid_reg;
  logic                  wr_done_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      READ: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        // rsp_valid_reg is high throughout RESP, so rsp_ready alone completes the handshake
        if (bus.rsp_ready && rsp_valid_reg) begin
          consume    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (accept) begin
      mem_addr_reg  <= bus.req_addr;
      mem_wdata_reg <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else if (capture) begin
      rsp_data_reg  <= bus.mem_rdata;
      rsp_err_reg   <= ~bus.mem_valid;
      rsp_valid_reg <= 1'b1;
    end else if (consume) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_done_reg <= 1'b0;
    end else begin
      wr_done_reg <= commit;
    end
  end

  // ---------------------------------------------------------------- saturating counters
  // index 0 counts committed writes, index 1 counts consumed read responses
  logic [1:0] cnt_inc;
  assign cnt_inc = {consume, commit};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] count_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != {CNT_WIDTH{1'b1}})) begin
          count_reg <= count_reg + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- outputs
  assign bus.req_ready = (state_reg == IDLE);
  assign bus.mem_en    = (state_reg == WRITE);
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.wr_done   = wr_done_reg;
  assign bus.wr_count  = g_cnt[0].count_reg;
  assign bus.rd_count  = g_cnt[1].count_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized transaction-level bench for mem_access_ctrl against a word-array memory model,
// with a second CNT_WIDTH=2 instance in lockstep for counter saturation.
module tb_mem_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
  mem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2))  bus2 ();

  mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_we    = bus.req_we;
  assign bus2.req_addr  = bus.req_addr;
  assign bus2.req_wdata = bus.req_wdata;
  assign bus2.rsp_ready = bus.rsp_ready;
  assign bus2.mem_rdata = bus.mem_rdata;
  assign bus2.mem_valid = bus.mem_valid;

  // Single-port RAM stand-in: en=1 writes, otherwise registered read; reset_n = ~reset clears it
  logic [DW-1:0] ram [16];
  logic          ram_fault = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      bus.mem_rdata <= '0;
      bus.mem_valid <= 1'b0;
    end else if (bus.mem_en) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_valid     <= 1'b0;
    end else begin
      bus.mem_rdata <= ram[bus.mem_addr];
      bus.mem_valid <= ~ram_fault;
    end
  end

  // Reference model: contents as seen by the requester, plus transaction totals
  logic [DW-1:0] ref_mem [16];
  int n_wr = 0;
  int n_rd = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] sat(input int n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (longint'(n) > lim) ? lim : longint'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    n_wr = 0;
    n_rd = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req_ready"}, bus.req_ready, 1);
    check({tag, ".rsp_valid"}, bus.rsp_valid, 0);
    check({tag, ".rsp_data"},  bus.rsp_data, 0);
    check({tag, ".rsp_err"},   bus.rsp_err, 0);
    check({tag, ".wr_done"},   bus.wr_done, 0);
    check({tag, ".mem_en"},    bus.mem_en, 0);
    check({tag, ".mem_addr"},  bus.mem_addr, 0);
    check({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    check({tag, ".wr_count"},  bus.wr_count, 0);
    check({tag, ".rd_count"},  bus.rd_count, 0);
    check({tag, ".wr_count2"}, bus2.wr_count, 0);
  endtask

  task automatic scramble_req();
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = $urandom;
  endtask

  // All tasks start and end at posedge+1 with the controller idle
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit gap);
    check("wr.req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk); #1;                                   // E0
    bus.req_valid = 1'b0;
    scramble_req();
    check("wr.req_ready_busy", bus.req_ready, 0);
    check("wr.mem_en", bus.mem_en, 1);
    check("wr.mem_addr", bus.mem_addr, a);
    check("wr.mem_wdata", bus.mem_wdata, d);
    @(posedge clk); #1;                                   // E1
    ref_mem[a] = d;
    n_wr++;
    check("wr.wr_done", bus.wr_done, 1);
    check("wr.mem_en_off", bus.mem_en, 0);
    check("wr.wr_count", bus.wr_count, sat(n_wr, 16));
    check("wr.wr_count_sat2", bus2.wr_count, sat(n_wr, 2));
    $display("write addr=%0d data=0x%08h wr_count=%0d wr_count2=%0d", a, d, bus.wr_count, bus2.wr_count);
    if (gap) begin
      @(posedge clk); #1;
      check("wr.wr_done_pulse", bus.wr_done, 0);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int stall, input bit fault);
    logic [DW-1:0] exp_d;
    exp_d = ref_mem[a];
    check("rd.req_ready_idle", bus.req_ready, 1);
    bus.rsp_ready = (stall == 0);
    ram_fault = fault;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.req_wdata = $urandom;
    @(posedge clk); #1;                                   // E0
    bus.req_valid = 1'b0;
    scramble_req();
    check("rd.req_ready_busy", bus.req_ready, 0);
    check("rd.mem_en", bus.mem_en, 0);
    check("rd.mem_addr", bus.mem_addr, a);
    @(posedge clk); #1;                                   // E1
    ram_fault = 1'b0;
    check("rd.rsp_valid_early", bus.rsp_valid, 0);
    @(posedge clk); #1;                                   // E2
    check("rd.rsp_valid", bus.rsp_valid, 1);
    check("rd.rsp_data", bus.rsp_data, exp_d);
    check("rd.rsp_err", bus.rsp_err, fault);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("rd.hold_valid", bus.rsp_valid, 1);
      check("rd.hold_data", bus.rsp_data, exp_d);
      check("rd.hold_err", bus.rsp_err, fault);
      check("rd.hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;                                   // consume edge
    n_rd++;
    bus.rsp_ready = 1'($urandom);
    check("rd.rsp_valid_clr", bus.rsp_valid, 0);
    check("rd.req_ready_back", bus.req_ready, 1);
    check("rd.rd_count", bus.rd_count, sat(n_rd, 16));
    check("rd.rd_count_sat2", bus2.rd_count, sat(n_rd, 2));
    $display("read  addr=%0d data=0x%08h err=%0d stall=%0d rd_count=%0d", a, exp_d, fault, stall, bus.rd_count);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    scramble_req();
    model_reset();
    #1;
    check_reset_values("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_values("post_release");

    // Write then read back, no backpressure
    do_write(4'd3, 32'hDEADBEEF, 1'b1);
    do_read(4'd3, 0, 1'b0);
    // Backpressure
    do_read(4'd3, 5, 1'b0);
    // Address extremes
    do_write(4'd15, 32'h1, 1'b0);
    do_write(4'd0, 32'h2, 1'b1);
    do_read(4'd15, 0, 1'b0);
    do_read(4'd0, 0, 1'b0);
    // RAM reports an invalid read
    do_read(4'd3, 1, 1'b1);

    // Randomized mix
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom), $urandom, 1'($urandom));
      else
        do_read(AW'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // Reset mid-cycle while in WRITE: write is dropped
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd7; bus.req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("rst_in_write");
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_write.wr_done", bus.wr_done, 0);
    check("rst_in_write.wr_count", bus.wr_count, 0);
    do_read(4'd7, 0, 1'b0);

    // Reset while in CAPTURE: response dropped, RAM cleared
    do_write(4'd5, 32'hCAFE_F00D, 1'b1);
    do_read(4'd5, 0, 1'b0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd5;
    @(posedge clk); #1;                                   // E0 -> READ
    bus.req_valid = 1'b0;
    @(posedge clk); #1;                                   // E1 -> CAPTURE
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("rst_in_capture");
    @(posedge clk); #1;
    check("rst_in_capture.rsp_valid_held", bus.rsp_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_capture.rsp_valid_after", bus.rsp_valid, 0);
    check("rst_in_capture.rd_count", bus.rd_count, 0);
    do_read(4'd5, 0, 1'b0);

    // Saturation of the 2-bit instance
    for (int t = 0; t < 5; t++) do_write(AW'(t), 32'hA0 + t, 1'b0);
    check("sat.wr_count2_final", bus2.wr_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
